// File: rtl/wb_dma_pkg.sv
// rtl/wb_dma_pkg.sv - shared register offsets, CTRL bit indices and FSM states for wb_dma
package wb_dma_pkg;

   localparam logic [1:0] REG_SRC  = 2'd0;
   localparam logic [1:0] REG_DST  = 2'd1;
   localparam logic [1:0] REG_LEN  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int CTRL_START   = 0;
   localparam int CTRL_DONE    = 1;
   localparam int CTRL_ERR     = 2;
   localparam int CTRL_IRQ_EN  = 3;
   localparam int CTRL_FIX_SRC = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } dma_state_t;

endpackage

// File: rtl/wb_dma_regs.sv
// rtl/wb_dma_regs.sv - wb_dma slave decode, registered ack and register file
// CTRL.FIX_SRC exists only when WB_DMA_FIXED_SRC_EN is defined.
module wb_dma_regs
   import wb_dma_pkg::*;
#(
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          wb_adr_i,
   input  logic [31:0]          wb_dat_i,
   output logic [31:0]          wb_dat_o,
   input  logic [3:0]           wb_sel_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_we_i,
   output logic                 wb_ack_o,
   input  logic                 busy,
   input  logic                 done_set,
   input  logic                 err_set,
   output logic                 start,
   output logic [31:2]          src,
   output logic [31:2]          dst,
   output logic [LEN_WIDTH-1:0] len,
   output logic                 fix_src,
   output logic                 intr
);

   logic [1:0]  reg_sel;
   logic        access;
   logic        wr_access;
   logic        ctrl_wr;
   logic        start_req;
   logic        zero_pend;
   logic        done;
   logic        err;
   logic        irq_en;
   logic [31:0] rd_data;
   logic        unused_bits;

   assign reg_sel     = wb_adr_i[3:2];
   assign access      = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign wr_access   = access & wb_we_i;
   assign ctrl_wr     = wr_access & (reg_sel == REG_CTRL);
   assign start_req   = ctrl_wr & wb_dat_i[CTRL_START] & ~busy;
   assign start       = start_req & (len != '0);
   assign intr        = done & irq_en;
   assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_SRC: rd_data = {src, 2'b00};
         REG_DST: rd_data = {dst, 2'b00};
         REG_LEN: rd_data[LEN_WIDTH-1:0] = len;
         default: begin
            rd_data[CTRL_START]   = busy;
            rd_data[CTRL_DONE]    = done;
            rd_data[CTRL_ERR]     = err;
            rd_data[CTRL_IRQ_EN]  = irq_en;
            rd_data[CTRL_FIX_SRC] = fix_src;
         end
      endcase
   end

`ifdef WB_DMA_FIXED_SRC_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fix_src <= 1'b0;
      end else if (ctrl_wr && !busy) begin
         fix_src <= wb_dat_i[CTRL_FIX_SRC];
      end
   end
`else
   assign fix_src = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_ack_o  <= 1'b0;
         wb_dat_o  <= '0;
         src       <= '0;
         dst       <= '0;
         len       <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         irq_en    <= 1'b0;
         zero_pend <= 1'b0;
      end else begin
         wb_ack_o  <= access;
         // a zero-length start completes one cycle later without touching the bus
         zero_pend <= start_req & (len == '0);
         if (access && !wb_we_i) begin
            wb_dat_o <= rd_data;
         end
         if (wr_access && !busy) begin
            case (reg_sel)
               REG_SRC: src <= wb_dat_i[31:2];
               REG_DST: dst <= wb_dat_i[31:2];
               REG_LEN: len <= wb_dat_i[LEN_WIDTH-1:0];
               default: ;
            endcase
         end
         if (ctrl_wr) begin
            irq_en <= wb_dat_i[CTRL_IRQ_EN];
            if (wb_dat_i[CTRL_DONE]) done <= 1'b0;
            if (wb_dat_i[CTRL_ERR])  err  <= 1'b0;
         end
         if (start_req) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
         // hardware status events take priority over a same-cycle software clear
         if (done_set || zero_pend) done <= 1'b1;
         if (err_set)               err  <= 1'b1;
      end
   end

endmodule

// File: rtl/wb_dma.sv
// rtl/wb_dma.sv - Wishbone block-copy engine: master FSM, working counters and data buffer
// Define WB_DMA_FIXED_SRC_EN to add CTRL.FIX_SRC (non-incrementing source).
module wb_dma
   import wb_dma_pkg::*;
#(
   parameter int LEN_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   output logic [31:0] m_adr_o,
   output logic [31:0] m_dat_o,
   input  logic [31:0] m_dat_i,
   output logic [3:0]  m_sel_o,
   output logic        m_we_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   input  logic        m_ack_i,
   input  logic        m_err_i,
   output logic        intr
);

   dma_state_t           state;
   dma_state_t           state_next;
   logic                 gap;
   logic [31:2]          cur_src;
   logic [31:2]          cur_dst;
   logic [LEN_WIDTH-1:0] remaining;
   logic [31:0]          buffer;
   logic [31:2]          src;
   logic [31:2]          dst;
   logic [LEN_WIDTH-1:0] len;
   logic                 start;
   logic                 fix_src;
   logic                 busy;
   logic                 active;
   logic                 bus_ack;
   logic                 bus_err;
   logic                 last_word;

   wb_dma_regs #(
      .LEN_WIDTH (LEN_WIDTH)
   ) u_regs (
      .clk      (clk),
      .reset    (reset),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_sel_i (wb_sel_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_we_i  (wb_we_i),
      .wb_ack_o (wb_ack_o),
      .busy     (busy),
      .done_set ((state == DONE) || bus_err),
      .err_set  (bus_err),
      .start    (start),
      .src      (src),
      .dst      (dst),
      .len      (len),
      .fix_src  (fix_src),
      .intr     (intr)
   );

   // gap is the one idle cycle that follows every acked phase
   assign busy      = (state != IDLE);
   assign active    = ((state == RD) || (state == WR)) && !gap;
   assign bus_err   = active & m_err_i;
   assign bus_ack   = active & m_ack_i & ~m_err_i;
   assign last_word = (remaining == LEN_WIDTH'(1));

   assign m_cyc_o = active;
   assign m_stb_o = active;
   assign m_we_o  = active & (state == WR);
   assign m_adr_o = {(state == WR) ? cur_dst : cur_src, 2'b00};
   assign m_dat_o = buffer;
   assign m_sel_o = 4'hF;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = RD;
         RD: begin
            if (bus_err)      state_next = IDLE;
            else if (bus_ack) state_next = WR;
         end
         WR: begin
            if (bus_err)      state_next = IDLE;
            else if (bus_ack) state_next = last_word ? DONE : RD;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         gap       <= 1'b0;
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
         buffer    <= '0;
      end else begin
         state <= state_next;
         gap   <= bus_ack;
         if (start) begin
            cur_src   <= src;
            cur_dst   <= dst;
            remaining <= len;
         end
         if (bus_ack && state == RD) begin
            buffer <= m_dat_i;
         end
         // word-granular counters wrap modulo 2^32 on their own
         if (bus_ack && state == WR) begin
            if (!fix_src) cur_src <= cur_src + 30'd1;
            cur_dst   <= cur_dst + 30'd1;
            remaining <= remaining - LEN_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_dma.sv
// tb/tb_wb_dma.sv - scoreboard bench for wb_dma: copies, zero length, bus error, wait states, busy writes, reset
module tb_wb_dma;
   import wb_dma_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
   logic [31:0] m_adr_o, m_dat_o, m_dat_i;
   logic [3:0]  m_sel_o;
   logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i, intr;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } bus_op_t;

   bus_op_t     exp_bus[$];
   logic [31:0] exp_reg[$];
   logic [31:0] mem [logic [31:0]];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_bus = 0;
   int          wait_states = 0;
   int          err_on_write = 0;
   int          wr_count = 0;
   logic        chk_drop = 1'b0;

   always #5 clk = ~clk;

   wb_dma dut (
      .clk(clk), .reset(reset),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
      .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
      .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i),
      .m_err_i(m_err_i), .intr(intr)
   );

   // bus slave model answering the DMA master port
   initial begin
      int cnt;
      cnt = 0;
      m_ack_i = 1'b0;
      m_err_i = 1'b0;
      m_dat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         m_ack_i = 1'b0;
         m_err_i = 1'b0;
         if (m_cyc_o && m_stb_o) begin
            if (cnt >= wait_states) begin
               m_ack_i = 1'b1;
               cnt = 0;
               if (m_we_o) begin
                  wr_count++;
                  if (wr_count == err_on_write) m_err_i = 1'b1;
               end else begin
                  m_dat_i = mem.exists(m_adr_o) ? mem[m_adr_o] : 32'h0;
               end
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // monitor: pops the scoreboard whenever the DUT completes a bus or register cycle
   always @(negedge clk) begin : monitor
      bus_op_t     e;
      logic [31:0] er;
      if (chk_drop) begin
         chk_drop = 1'b0;
         n_cmp++;
         if (m_cyc_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_cyc_drop: got m_cyc_o=%0b expected 0", m_cyc_o);
         end
      end
      if (m_cyc_o && m_stb_o && (m_ack_i || m_err_i)) begin
         n_bus++;
         n_cmp++;
         if (exp_bus.size() == 0) begin
            n_bad++;
            $display("FAIL bus_unexpected: got we=%0b adr=%h dat=%h expected no cycle", m_we_o, m_adr_o, m_dat_o);
         end else begin
            e = exp_bus.pop_front();
            if (m_we_o !== e.we || m_adr_o !== e.adr || (e.we && m_dat_o !== e.dat)) begin
               n_bad++;
               $display("FAIL bus_op: got we=%0b adr=%h dat=%h expected we=%0b adr=%h dat=%h",
                        m_we_o, m_adr_o, m_dat_o, e.we, e.adr, e.dat);
            end
         end
         if (m_err_i) chk_drop = 1'b1;
      end
      if (wb_ack_o && !wb_we_i) begin
         n_cmp++;
         if (exp_reg.size() == 0) begin
            n_bad++;
            $display("FAIL reg_unexpected: got %h expected no read", wb_dat_o);
         end else begin
            er = exp_reg.pop_front();
            if (wb_dat_o !== er) begin
               n_bad++;
               $display("FAIL reg_read: got %h expected %h", wb_dat_o, er);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [1:0] r, input logic [31:0] d);
      int t;
      wb_adr_i = {28'h0, r, 2'b00};
      wb_dat_i = d;
      wb_we_i  = we;
      wb_stb_i = 1'b1;
      wb_cyc_i = 1'b1;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!wb_ack_o && t < 20);
      if (!wb_ack_o) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wb_ack_timeout: got no ack expected ack within 20 cycles");
         exp_reg.delete();
      end
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wb_wr(input logic [1:0] r, input logic [31:0] d);
      wb_xfer(1'b1, r, d);
   endtask

   task automatic wb_rd(input logic [1:0] r, input logic [31:0] exp);
      exp_reg.push_back(exp);
      wb_xfer(1'b0, r, 32'h0);
   endtask

   task automatic bus_rd(input logic [31:0] a);
      exp_bus.push_back('{we: 1'b0, adr: a, dat: 32'h0});
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      exp_bus.push_back('{we: 1'b1, adr: a, dat: d});
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_bus.size() != 0 && t < 400) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_pending", 32'(exp_bus.size()), 32'h0);
      exp_bus.delete();
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected finish before 40000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      int t;
      reset    = 1'b1;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = 4'hF;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_cyc", 32'(m_cyc_o), 32'h0);
      check("rst_m_stb_we", 32'(m_stb_o | m_we_o), 32'h0);
      check("rst_m_sel", 32'(m_sel_o), 32'hF);
      check("rst_m_adr", m_adr_o, 32'h0);
      check("rst_m_dat", m_dat_o, 32'h0);
      check("rst_wb_ack", 32'(wb_ack_o), 32'h0);
      check("rst_wb_dat", wb_dat_o, 32'h0);
      check("rst_intr", 32'(intr), 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      wb_rd(REG_SRC, 32'h0);
      wb_rd(REG_DST, 32'h0);
      wb_rd(REG_LEN, 32'h0);
      wb_rd(REG_CTRL, 32'h0);

      // basic 4-word copy, low address bits and upper LEN bits dropped
      mem[32'h100] = 32'hA000_0001;
      mem[32'h104] = 32'hB000_0002;
      mem[32'h108] = 32'hC000_0003;
      mem[32'h10C] = 32'hD000_0004;
      wb_wr(REG_SRC, 32'h0000_0103);
      wb_wr(REG_DST, 32'h4000_0000);
      wb_wr(REG_LEN, 32'hFFFF_0004);
      wb_rd(REG_SRC, 32'h0000_0100);
      wb_rd(REG_DST, 32'h4000_0000);
      wb_rd(REG_LEN, 32'h0000_0004);
      bus_rd(32'h100); bus_wr(32'h4000_0000, 32'hA000_0001);
      bus_rd(32'h104); bus_wr(32'h4000_0004, 32'hB000_0002);
      bus_rd(32'h108); bus_wr(32'h4000_0008, 32'hC000_0003);
      bus_rd(32'h10C); bus_wr(32'h4000_000C, 32'hD000_0004);
      n0 = n_bus;
      wb_wr(REG_CTRL, 32'h1);
      wait_drain();
      check("t1_bus_count", 32'(n_bus - n0), 32'd8);
      wb_rd(REG_CTRL, 32'h2);
      check("t1_intr", 32'(intr), 32'h0);

      // zero length with interrupt enabled
      wb_wr(REG_LEN, 32'h0);
      n0 = n_bus;
      wb_wr(REG_CTRL, 32'h9);
      check("t2_intr_set", 32'(intr), 32'h1);
      repeat (4) @(posedge clk);
      #1;
      check("t2_bus_count", 32'(n_bus - n0), 32'd0);
      wb_rd(REG_CTRL, 32'hA);
      wb_wr(REG_CTRL, 32'h2);
      check("t2_intr_clr", 32'(intr), 32'h0);
      wb_rd(REG_CTRL, 32'h0);

      // bus error on the second write of a 3-word copy
      mem[32'h200] = 32'h1234_5678;
      mem[32'h204] = 32'h9ABC_DEF0;
      mem[32'h208] = 32'h0F0F_0F0F;
      wb_wr(REG_SRC, 32'h200);
      wb_wr(REG_DST, 32'h300);
      wb_wr(REG_LEN, 32'h3);
      wr_count = 0;
      err_on_write = 2;
      bus_rd(32'h200); bus_wr(32'h300, 32'h1234_5678);
      bus_rd(32'h204); bus_wr(32'h304, 32'h9ABC_DEF0);
      n0 = n_bus;
      wb_wr(REG_CTRL, 32'h1);
      wait_drain();
      repeat (10) @(posedge clk);
      #1;
      check("t3_bus_count", 32'(n_bus - n0), 32'd4);
      err_on_write = 0;
      wb_rd(REG_CTRL, 32'h6);
      wb_wr(REG_CTRL, 32'h6);
      wb_rd(REG_CTRL, 32'h0);

      // three wait states, destination wraps past 2^32
      wait_states = 3;
      mem[32'h400] = 32'hCAFE_F00D;
      mem[32'h404] = 32'h0BAD_BEEF;
      wb_wr(REG_SRC, 32'h400);
      wb_wr(REG_DST, 32'hFFFF_FFFC);
      wb_wr(REG_LEN, 32'h2);
      bus_rd(32'h400); bus_wr(32'hFFFF_FFFC, 32'hCAFE_F00D);
      bus_rd(32'h404); bus_wr(32'h0000_0000, 32'h0BAD_BEEF);
      n0 = n_bus;
      wb_wr(REG_CTRL, 32'h1);
      wait_drain();
      check("t4_bus_count", 32'(n_bus - n0), 32'd4);
      wb_rd(REG_CTRL, 32'h2);

      // writes while busy are ignored
      mem[32'h1000] = 32'h0101_0101;
      mem[32'h1004] = 32'h0202_0202;
      mem[32'h1008] = 32'h0303_0303;
      wb_wr(REG_SRC, 32'h1000);
      wb_wr(REG_DST, 32'h2000);
      wb_wr(REG_LEN, 32'h3);
      bus_rd(32'h1000); bus_wr(32'h2000, 32'h0101_0101);
      bus_rd(32'h1004); bus_wr(32'h2004, 32'h0202_0202);
      bus_rd(32'h1008); bus_wr(32'h2008, 32'h0303_0303);
      wb_wr(REG_CTRL, 32'h1);
      wb_wr(REG_SRC, 32'hDEAD_0000);
      wb_wr(REG_LEN, 32'h7);
      wb_wr(REG_CTRL, 32'h1);
      wb_rd(REG_SRC, 32'h1000);
      wb_rd(REG_LEN, 32'h3);
      wb_rd(REG_CTRL, 32'h1);
      wait_drain();
      wb_rd(REG_CTRL, 32'h2);

      // reset in the middle of a write phase
      wb_wr(REG_DST, 32'h3000);
      wb_wr(REG_LEN, 32'h2);
      bus_rd(32'h1000);
      wb_wr(REG_CTRL, 32'h9);
      t = 0;
      while (!(m_cyc_o && m_we_o) && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("t5_reached_wr", 32'(m_cyc_o & m_we_o), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_cyc", 32'(m_cyc_o), 32'h0);
      check("t5_rst_intr", 32'(intr), 32'h0);
      reset = 1'b0;
      check("t5_bus_pending", 32'(exp_bus.size()), 32'h0);
      exp_bus.delete();
      wb_rd(REG_SRC, 32'h0);
      wb_rd(REG_DST, 32'h0);
      wb_rd(REG_LEN, 32'h0);
      wb_rd(REG_CTRL, 32'h0);
      wait_states = 0;

`ifdef WB_DMA_FIXED_SRC_EN
      mem[32'h7004_0000] = 32'h55AA_0001;
      wb_wr(REG_SRC, 32'h7004_0000);
      wb_wr(REG_DST, 32'h9000);
      wb_wr(REG_LEN, 32'h3);
      bus_rd(32'h7004_0000); bus_wr(32'h9000, 32'h55AA_0001);
      bus_rd(32'h7004_0000); bus_wr(32'h9004, 32'h55AA_0001);
      bus_rd(32'h7004_0000); bus_wr(32'h9008, 32'h55AA_0001);
      wb_wr(REG_CTRL, 32'h11);
      wait_drain();
      wb_rd(REG_CTRL, 32'h12);
`endif

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
